// File: rtl/video_capture_ctrl.sv
// Frame-capture sequencer: arms on start, skips frames, captures a configured number of
// whole frames with optional spacing, gates the pixel strobe and flags wrong-sized frames.
module video_capture_ctrl #(
  parameter int unsigned WIDTH  = 640,
  parameter int unsigned HEIGHT = 480,
  parameter int unsigned NW     = 8,
  parameter int unsigned PCW    = 20
) (
  input  logic          vid_clk,
  input  logic          vid_rst_n,
  input  logic          vid_clk_en,
  input  logic          vid_vsync,
  input  logic          vid_active,
  input  logic [NW-1:0] cfg_skip,
  input  logic [NW-1:0] cfg_interval,
  input  logic [NW-1:0] cfg_count,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          cap_active,
  output logic          cap_pix_valid,
  output logic          cap_frame_start,
  output logic          cap_frame_done,
  output logic [NW-1:0] cap_frame_idx,
  output logic          err_size
);

  localparam logic [PCW-1:0] FramePix = PCW'(WIDTH * HEIGHT);

  typedef enum logic [2:0] {StIdle, StArm, StSkip, StCapture, StGap, StDone} state_e;

  state_e         state_q, state_d;
  logic           vsync_d_q;
  logic [NW-1:0]  rem_q, rem_d;
  logic [PCW-1:0] pix_cnt_q, pix_cnt_d;
  logic           ovf_q, ovf_d;
  logic [NW-1:0]  idx_q, idx_d;
  logic           err_q, err_d;
  logic [NW-1:0]  skip_q, skip_d;
  logic [NW-1:0]  interval_q, interval_d;
  logic [NW-1:0]  count_q, count_d;
  logic           fstart_q, fstart_d;
  logic           fdone_q, fdone_d;

  logic          fe;
  logic          pix_in;
  logic          pix_ok;
  logic [NW-1:0] idx_new;

  assign fe      = vid_clk_en & vid_vsync & ~vsync_d_q;
  assign pix_in  = vid_clk_en & vid_active;
  assign pix_ok  = (pix_cnt_q < FramePix);
  assign idx_new = idx_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    pix_cnt_d  = pix_cnt_q;
    ovf_d      = ovf_q;
    idx_d      = idx_q;
    err_d      = err_q;
    skip_d     = skip_q;
    interval_d = interval_q;
    count_d    = count_q;
    fstart_d   = 1'b0;
    fdone_d    = 1'b0;

    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          // A frame edge coinciding with start is deliberately not acted on.
          if (start) begin
            skip_d     = cfg_skip;
            interval_d = cfg_interval;
            count_d    = cfg_count;
            err_d      = 1'b0;
            idx_d      = '0;
            state_d    = (cfg_count == '0) ? StDone : StArm;
          end
        end
        StArm: begin
          if (fe) begin
            if (skip_q == '0) begin
              state_d   = StCapture;
              fstart_d  = 1'b1;
              pix_cnt_d = '0;
              ovf_d     = 1'b0;
            end else begin
              state_d = StSkip;
              rem_d   = skip_q - 1'b1;
            end
          end
        end
        StSkip, StGap: begin
          if (fe) begin
            if (rem_q == '0) begin
              state_d   = StCapture;
              fstart_d  = 1'b1;
              pix_cnt_d = '0;
              ovf_d     = 1'b0;
            end else begin
              rem_d = rem_q - 1'b1;
            end
          end
        end
        StCapture: begin
          if (pix_in) begin
            if (pix_ok) pix_cnt_d = pix_cnt_q + 1'b1;
            else        ovf_d     = 1'b1;
          end
          if (fe) begin
            fdone_d = 1'b1;
            idx_d   = idx_new;
            if ((pix_cnt_q != FramePix) || ovf_q) err_d = 1'b1;
            if (idx_new == count_q) begin
              state_d = StDone;
            end else if (interval_q == '0) begin
              // Back-to-back capture: next frame opens on the same edge.
              fstart_d  = 1'b1;
              pix_cnt_d = '0;
              ovf_d     = 1'b0;
            end else begin
              state_d = StGap;
              rem_d   = interval_q - 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge vid_clk or negedge vid_rst_n) begin
    if (!vid_rst_n) begin
      state_q    <= StIdle;
      vsync_d_q  <= 1'b0;
      rem_q      <= '0;
      pix_cnt_q  <= '0;
      ovf_q      <= 1'b0;
      idx_q      <= '0;
      err_q      <= 1'b0;
      skip_q     <= '0;
      interval_q <= '0;
      count_q    <= '0;
      fstart_q   <= 1'b0;
      fdone_q    <= 1'b0;
    end else begin
      if (vid_clk_en) vsync_d_q <= vid_vsync;
      state_q    <= state_d;
      rem_q      <= rem_d;
      pix_cnt_q  <= pix_cnt_d;
      ovf_q      <= ovf_d;
      idx_q      <= idx_d;
      err_q      <= err_d;
      skip_q     <= skip_d;
      interval_q <= interval_d;
      count_q    <= count_d;
      fstart_q   <= fstart_d;
      fdone_q    <= fdone_d;
    end
  end

  assign busy            = (state_q == StArm) || (state_q == StSkip) ||
                           (state_q == StCapture) || (state_q == StGap);
  assign done            = (state_q == StDone);
  assign cap_active      = (state_q == StCapture);
  assign cap_pix_valid   = (state_q == StCapture) & pix_in & pix_ok;
  assign cap_frame_start = fstart_q;
  assign cap_frame_done  = fdone_q;
  assign cap_frame_idx   = idx_q;
  assign err_size        = err_q;

endmodule
